uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver for the AHB UART, the stage directly downstream of UART_TX. It consumes the `tx` line driven by UART_TX (or an external pin) and the 16x oversampling `baudtick` from BAUDGEN. It deframes 8N1 characters using mid-bit majority voting and presents each byte in a one-entry holding register with a valid/read handshake. It reports framing errors and overruns.

## Interface
- DATA_BITS, 8, data bits per frame, LSB first
- OVERSAMPLE, 16, b_tick pulses per bit period (even, ≥8)
- clk  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- b_tick  in  1  single-cycle pulse from BAUDGEN, OVERSAMPLE per bit
- rx  in  1  serial input, idle high, asynchronous to clk
- rd  in  1  consumer read strobe; clears data_valid
- err_clr  in  1  clears overrun
- dout  out  DATA_BITS  received byte holding register
- data_valid  out  1  holding register full, held until rd
- rx_done  out  1  one-cycle pulse when a good frame is written to dout
- frame_err  out  1  one-cycle pulse when the stop bit samples 0
- overrun  out  1  sticky; a good frame arrived while data_valid=1

## Operation
- rx passes through a 2-flop synchronizer (rx_s). Both flops reset to 1.
- Tick counter `tcnt` (0..OVERSAMPLE-1) advances only on b_tick. Bit counter `bcnt` counts 0..DATA_BITS-1.
- Each bit is sampled on ticks OVERSAMPLE/2-1, /2, /2+1 (7, 8, 9). The bit value is the majority of the three samples.
- `armed` flag: set on any b_tick with rx_s=1. Cleared on entry to START.
- States:
  - IDLE: on b_tick with rx_s=0 and armed=1, go to START with tcnt=0.
  - START: at tick 9, if the vote is 1 (false start), go to IDLE. Otherwise continue. At tick OVERSAMPLE-1, go to DATA with bcnt=0.
  - DATA: the vote at tick 9 shifts into the shift register MSB, shifting right. At tick OVERSAMPLE-1, if bcnt=DATA_BITS-1, go to STOP. Otherwise increment bcnt.
  - STOP: decide at tick 9 and go to IDLE in the same cycle. This gives a half-bit early resync window.
- Stop vote = 1 (good frame):
  - If data_valid=0, or rd is asserted in the same cycle: load dout, pulse rx_done, data_valid=1.
  - Otherwise: discard the byte, keep dout, set overrun; rx_done is not pulsed.
- Stop vote = 0: pulse frame_err and discard the byte. dout and data_valid are unchanged. armed=0, so a held-low line (break) never starts a frame until rx_s returns high.
- rd with data_valid=1 clears data_valid next cycle. rd with data_valid=0 is ignored. dout is not cleared by rd.
- err_clr clears overrun. If err_clr and a new overrun occur in the same cycle, overrun=1.
- All state and the bit vote use only synchronized rx_s and b_tick. No logic runs on clk edges without b_tick except the handshake and flags.

## Timing
- Reset values: dout=0, data_valid=0, rx_done=0, frame_err=0, overrun=0. State=IDLE, tcnt=0, bcnt=0, armed=0, synchronizer=1.
- Reset is asynchronous. Asserting it mid-frame aborts immediately, with no partial byte and no flag.
- rx to rx_s: 2 clk cycles.
- rx_done, frame_err, dout and data_valid update on the clk edge following the b_tick that is tick 9 of the stop bit.
- Frame-to-rx_done latency: (1 + DATA_BITS)·OVERSAMPLE + 10 b_ticks, measured from the first low-sampled b_tick.
- rx_done and frame_err are exactly one clk wide and never both high.
- Back-to-back frames with zero idle time are received without loss.

## Test plan
- Loopback UART_TX→uart_rx, BAUDGEN at 50 MHz / 19200: send 0xA5, then pulse rd after rx_done.
  - Required: one rx_done pulse; dout=0xA5; data_valid=1 until the rd edge, then 0; frame_err=0; overrun=0.
- False start: drive rx low for 4 b_ticks, then high, then send frame 0x3C.
  - Required: no rx_done or frame_err for the glitch; 0x3C is received correctly.
- Framing error: send 0x55 with the stop bit forced 0, hold rx low for 3 bit times, release, then send 0x0F.
  - Required: one frame_err pulse; data_valid stays 0; no start detected while low; 0x0F is received.
- Overrun: send 0x11 then 0x22 with no rd.
  - Required: dout=0x11, data_valid=1, overrun=1, one rx_done only.
  - Then err_clr: overrun=0. Then rd coincident with the stop decision of 0x33: dout=0x33, data_valid=1, overrun=0.
- Glitch immunity: send 0xFF while forcing rx low for a single b_tick at tick 8 of data bit 2.
  - Required: dout=0xFF, no frame_err.
- Reset mid-frame: assert resetn=0 during data bit 3 of 0x81, release, then send 0x81 again.
  - Required: all outputs at reset values during reset; exactly one rx_done after release with dout=0x81.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, 16x oversampled mid-bit majority vote,
// one-entry holding register with valid/read handshake, framing error and overrun flags.
`timescale 1ns/1ps
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 b_tick,
  input  logic                 rx,
  input  logic                 rd,
  input  logic                 err_clr,
  output logic [DATA_BITS-1:0] dout,
  output logic                 data_valid,
  output logic                 rx_done,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] TICK_S0   = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_S1   = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] TICK_S2   = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state_q, state_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic                 armed_q, armed_d;
  logic [1:0]           samp_q, samp_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 data_valid_q, data_valid_d;
  logic                 rx_done_q, rx_done_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 rx_meta_q, rx_meta_d;
  logic                 rx_s_q, rx_s_d;
  logic                 vote;

  // Majority of the samples taken at the two ticks before the current one and now.
  assign vote = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);

  always_comb begin
    state_d      = state_q;
    tcnt_d       = tcnt_q;
    bcnt_d       = bcnt_q;
    armed_d      = armed_q;
    samp_d       = samp_q;
    shift_d      = shift_q;
    dout_d       = dout_q;
    data_valid_d = data_valid_q;
    overrun_d    = overrun_q;
    rx_done_d    = 1'b0;
    frame_err_d  = 1'b0;
    rx_meta_d    = rx;
    rx_s_d       = rx_meta_q;

    if (rd && data_valid_q) data_valid_d = 1'b0;
    if (err_clr) overrun_d = 1'b0;

    if (b_tick) begin
      if (rx_s_q) armed_d = 1'b1;
      tcnt_d = (tcnt_q == TICK_LAST) ? '0 : tcnt_q + 1'b1;
      if (tcnt_q == TICK_S0) samp_d[0] = rx_s_q;
      if (tcnt_q == TICK_S1) samp_d[1] = rx_s_q;

      case (state_q)
        IDLE: begin
          tcnt_d = '0;
          if (!rx_s_q && armed_q) begin
            state_d = START;
            armed_d = 1'b0;
          end
        end
        START: begin
          if (tcnt_q == TICK_S2 && vote) begin
            state_d = IDLE;
            tcnt_d  = '0;
          end else if (tcnt_q == TICK_LAST) begin
            state_d = DATA;
            bcnt_d  = '0;
          end
        end
        DATA: begin
          if (tcnt_q == TICK_S2) shift_d = {vote, shift_q[DATA_BITS-1:1]};
          if (tcnt_q == TICK_LAST) begin
            if (bcnt_q == BIT_LAST) state_d = STOP;
            else                    bcnt_d  = bcnt_q + 1'b1;
          end
        end
        STOP: begin
          // Deciding mid stop bit leaves half a bit to resync on the next start edge.
          if (tcnt_q == TICK_S2) begin
            state_d = IDLE;
            tcnt_d  = '0;
            if (vote) begin
              if (!data_valid_q || rd) begin
                dout_d       = shift_q;
                data_valid_d = 1'b1;
                rx_done_d    = 1'b1;
              end else begin
                overrun_d = 1'b1;
              end
            end else begin
              frame_err_d = 1'b1;
              armed_d     = 1'b0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      tcnt_q       <= '0;
      bcnt_q       <= '0;
      armed_q      <= 1'b0;
      samp_q       <= '0;
      shift_q      <= '0;
      dout_q       <= '0;
      data_valid_q <= 1'b0;
      rx_done_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      tcnt_q       <= tcnt_d;
      bcnt_q       <= bcnt_d;
      armed_q      <= armed_d;
      samp_q       <= samp_d;
      shift_q      <= shift_d;
      dout_q       <= dout_d;
      data_valid_q <= data_valid_d;
      rx_done_q    <= rx_done_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      rx_meta_q    <= rx_meta_d;
      rx_s_q       <= rx_s_d;
    end
  end

  assign dout       = dout_q;
  assign data_valid = data_valid_q;
  assign rx_done    = rx_done_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames push expected pulses, a monitor
// pops and checks byte, pulse kind and b_tick latency whenever rx_done/frame_err fire.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int K_NONE = 0;
  localparam int K_DONE = 1;
  localparam int K_FERR = 2;
  // Detection b_tick follows the start-bit drive by one tick; decision is 154 ticks later.
  localparam int LATENCY = 1 + (1 + 8) * 16 + 10;

  logic       clk = 1'b0;
  logic       resetn;
  logic       b_tick;
  logic       rx;
  logic       rd;
  logic       err_clr;
  logic [7:0] dout;
  logic       data_valid;
  logic       rx_done;
  logic       frame_err;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  int tick_count = 0;
  int div = 0;
  int rd_target;

  typedef struct {
    logic       is_ferr;
    logic [7:0] data;
    int         tick;
  } exp_t;
  exp_t sb[$];

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk(clk), .resetn(resetn), .b_tick(b_tick), .rx(rx), .rd(rd), .err_clr(err_clr),
    .dout(dout), .data_valid(data_valid), .rx_done(rx_done), .frame_err(frame_err),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  // One b_tick every 4 clocks, changed on the falling edge.
  initial begin
    b_tick = 1'b0;
    forever begin
      @(negedge clk);
      div = (div == 3) ? 0 : div + 1;
      b_tick = (div == 0);
      if (b_tick) tick_count++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(posedge clk); while (b_tick !== 1'b1);
    end
    #1;
  endtask

  task automatic pulse_rd();
    rd = 1'b1;
    @(posedge clk);
    #1 rd = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic stop_val, input int glitch_bit,
                               input int kind, input int idle);
    exp_t e;
    if (idle > 0) begin
      rx = 1'b1;
      wait_ticks(idle);
    end
    if (kind != K_NONE) begin
      e.is_ferr = (kind == K_FERR);
      e.data    = data;
      e.tick    = tick_count + LATENCY;
      sb.push_back(e);
    end
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      if (i == glitch_bit) begin
        rx = 1'b1; wait_ticks(9);
        rx = 1'b0; wait_ticks(1);
        rx = 1'b1; wait_ticks(6);
      end else begin
        rx = data[i];
        wait_ticks(16);
      end
    end
    rx = stop_val;
    wait_ticks(16);
  endtask

  // Monitor: every output pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (resetn === 1'b1 && (rx_done === 1'b1 || frame_err === 1'b1)) begin
      checkOutput("pulse_exclusive", {31'b0, rx_done & frame_err}, 32'd0);
      if (sb.size() == 0) begin
        checkOutput("sb_pending", sb.size(), 32'd1);
      end else begin
        e = sb.pop_front();
        checkOutput("pulse_kind", {31'b0, frame_err}, {31'b0, e.is_ferr});
        if (!e.is_ferr) checkOutput("rx_data", dout, e.data);
        checkOutput("latency_tick", tick_count, e.tick);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    resetn = 1'b0; rx = 1'b1; rd = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_dout", dout, 32'd0);
    checkOutput("rst_valid", data_valid, 32'd0);
    checkOutput("rst_done", rx_done, 32'd0);
    checkOutput("rst_ferr", frame_err, 32'd0);
    checkOutput("rst_ovr", overrun, 32'd0);
    @(posedge clk);
    #1 resetn = 1'b1;
    wait_ticks(2);

    // Plain frame then read
    applyStimulus(8'hA5, 1'b1, -1, K_DONE, 4);
    checkOutput("a5_dout", dout, 32'hA5);
    checkOutput("a5_valid", data_valid, 32'd1);
    checkOutput("a5_ovr", overrun, 32'd0);
    pulse_rd();
    checkOutput("a5_valid_after_rd", data_valid, 32'd0);
    checkOutput("a5_dout_after_rd", dout, 32'hA5);

    // False start glitch then a real frame
    wait_ticks(1);
    rx = 1'b0; wait_ticks(4);
    rx = 1'b1; wait_ticks(16);
    applyStimulus(8'h3C, 1'b1, -1, K_DONE, 0);
    checkOutput("3c_dout", dout, 32'h3C);
    pulse_rd();

    // Framing error, held-low break, then recovery
    wait_ticks(1);
    applyStimulus(8'h55, 1'b0, -1, K_FERR, 2);
    wait_ticks(48);
    checkOutput("ferr_valid", data_valid, 32'd0);
    checkOutput("ferr_dout", dout, 32'h3C);
    applyStimulus(8'h0F, 1'b1, -1, K_DONE, 4);
    checkOutput("0f_valid", data_valid, 32'd1);
    pulse_rd();
    checkOutput("0f_valid_after_rd", data_valid, 32'd0);

    // Overrun, clear, then rd coincident with the stop decision
    wait_ticks(1);
    applyStimulus(8'h11, 1'b1, -1, K_DONE, 2);
    applyStimulus(8'h22, 1'b1, -1, K_NONE, 2);
    checkOutput("ovr_dout", dout, 32'h11);
    checkOutput("ovr_valid", data_valid, 32'd1);
    checkOutput("ovr_flag", overrun, 32'd1);
    err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
    checkOutput("ovr_cleared", overrun, 32'd0);
    wait_ticks(1);
    rd_target = tick_count + 2 + LATENCY;
    fork
      applyStimulus(8'h33, 1'b1, -1, K_DONE, 2);
      begin
        wait (tick_count == rd_target);
        #1 rd = 1'b1;
        @(posedge clk);
        #1 rd = 1'b0;
      end
    join
    checkOutput("33_dout", dout, 32'h33);
    checkOutput("33_valid", data_valid, 32'd1);
    checkOutput("33_ovr", overrun, 32'd0);
    pulse_rd();

    // Back-to-back frames with zero idle, reader always ready
    wait_ticks(1);
    rd = 1'b1;
    applyStimulus(8'h5A, 1'b1, -1, K_DONE, 2);
    applyStimulus(8'hC3, 1'b1, -1, K_DONE, 0);
    rd = 1'b0;
    checkOutput("b2b_valid", data_valid, 32'd0);
    checkOutput("b2b_ovr", overrun, 32'd0);

    // Single-tick glitch at a data-bit sample point
    applyStimulus(8'hFF, 1'b1, 2, K_DONE, 2);
    checkOutput("ff_dout", dout, 32'hFF);
    checkOutput("ff_valid", data_valid, 32'd1);

    // Reset during data bit 3, then a clean resend
    fork
      applyStimulus(8'h81, 1'b1, -1, K_NONE, 2);
      begin
        wait_ticks(74);
        resetn = 1'b0;
        @(negedge clk);
        checkOutput("midrst_dout", dout, 32'd0);
        checkOutput("midrst_valid", data_valid, 32'd0);
        checkOutput("midrst_done", rx_done, 32'd0);
        checkOutput("midrst_ferr", frame_err, 32'd0);
        checkOutput("midrst_ovr", overrun, 32'd0);
        wait_ticks(3);
        resetn = 1'b1;
      end
    join
    checkOutput("post_rst_valid", data_valid, 32'd0);
    applyStimulus(8'h81, 1'b1, -1, K_DONE, 2);
    checkOutput("81_dout", dout, 32'h81);
    checkOutput("81_valid", data_valid, 32'd1);

    wait_ticks(4);
    checkOutput("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
